// File: rtl/hazard_ctrl_pkg.sv
// Shared opcode map, instruction-class helpers and sequencer state encodings
// for the hazard/stall controller.
package hazard_ctrl_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_LW  = 4'b1000;
  localparam logic [OPC_W-1:0] OP_SW  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_B   = 4'b1100;
  localparam logic [OPC_W-1:0] OP_BR  = 4'b1101;
  localparam logic [OPC_W-1:0] OP_PCS = 4'b1110;
  localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_STALL,
    ST_MEMWAIT,
    ST_DRAIN,
    ST_HALT
  } state_t;

  // State to resume once a data-memory freeze ends.
  typedef enum logic [1:0] {
    RET_RUN,
    RET_STALL,
    RET_DRAIN
  } ret_t;

  // All ALU-class opcodes (0xxx) write a register, as do LW and PCS.
  function automatic logic is_writer(input logic [OPC_W-1:0] op);
    return (op[OPC_W-1] == 1'b0) || (op == OP_LW) || (op == OP_PCS);
  endfunction

  // ALU ops take Rt as a second operand; SW stores the value held in Rt.
  function automatic logic reads_rt(input logic [OPC_W-1:0] op);
    return (op[OPC_W-1] == 1'b0) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational hazard terms that forwarding cannot resolve: load-use and
// branch-register reads of a value not yet available in ID.
module hazard_detect
  import hazard_ctrl_pkg::*;
#(
  parameter int OPW = 4,
  parameter int RW  = 4
) (
  input  logic [OPW-1:0] IF_ID_Opcode,
  input  logic [RW-1:0]  IF_ID_Rs,
  input  logic [RW-1:0]  IF_ID_Rt,
  input  logic [OPW-1:0] ID_EX_Opcode,
  input  logic [RW-1:0]  ID_EX_Rd,
  input  logic [OPW-1:0] EX_MEM_Opcode,
  input  logic [RW-1:0]  EX_MEM_Rd,
  output logic           load_use,
  output logic           br_ex,
  output logic           br_mem
);

  logic ex_rd_live;
  logic mem_rd_live;
  logic id_is_br;
  logic ex_hits_rs;
  logic ex_hits_rt;
  logic mem_hits_rs;

  // R0 is hardwired to zero, so a write to it never creates a dependency.
  assign ex_rd_live  = (ID_EX_Rd  != '0);
  assign mem_rd_live = (EX_MEM_Rd != '0);
  assign id_is_br    = (IF_ID_Opcode == OP_BR);

  assign ex_hits_rs  = ex_rd_live  && (ID_EX_Rd  == IF_ID_Rs);
  assign ex_hits_rt  = ex_rd_live  && (ID_EX_Rd  == IF_ID_Rt) && reads_rt(IF_ID_Opcode);
  assign mem_hits_rs = mem_rd_live && (EX_MEM_Rd == IF_ID_Rs);

  assign load_use = (ID_EX_Opcode == OP_LW) && (ex_hits_rs || ex_hits_rt);
  assign br_ex    = id_is_br && is_writer(ID_EX_Opcode) && ex_hits_rs;
  assign br_mem   = id_is_br && (EX_MEM_Opcode == OP_LW) && mem_hits_rs;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage core: owns the PC and pipeline
// register enables, bubbles, the taken-branch flush and the HLT drain.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int OPW       = 4,
  parameter int RW        = 4,
  parameter int DRAIN_CYC = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] IF_ID_Opcode,
  input  logic [RW-1:0]  IF_ID_Rs,
  input  logic [RW-1:0]  IF_ID_Rt,
  input  logic [OPW-1:0] ID_EX_Opcode,
  input  logic [RW-1:0]  ID_EX_Rd,
  input  logic [OPW-1:0] EX_MEM_Opcode,
  input  logic [RW-1:0]  EX_MEM_Rd,
  input  logic           branch_taken,
  input  logic           dmem_busy,
  output logic           pc_en,
  output logic           if_id_en,
  output logic           if_id_flush,
  output logic           id_ex_bubble,
  output logic           ex_mem_en,
  output logic           mem_wb_en,
  output logic           halted
);

  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYC - 1);

  state_t     state, state_nxt;
  ret_t       ret, ret_nxt;
  logic [1:0] cnt, cnt_nxt;

  logic load_use;
  logic br_ex;
  logic br_mem;
  logic hazard;
  logic id_hlt;

  hazard_detect #(
    .OPW (OPW),
    .RW  (RW)
  ) u_detect (
    .IF_ID_Opcode  (IF_ID_Opcode),
    .IF_ID_Rs      (IF_ID_Rs),
    .IF_ID_Rt      (IF_ID_Rt),
    .ID_EX_Opcode  (ID_EX_Opcode),
    .ID_EX_Rd      (ID_EX_Rd),
    .EX_MEM_Opcode (EX_MEM_Opcode),
    .EX_MEM_Rd     (EX_MEM_Rd),
    .load_use      (load_use),
    .br_ex         (br_ex),
    .br_mem        (br_mem)
  );

  assign hazard = load_use | br_ex | br_mem;
  assign id_hlt = (IF_ID_Opcode == OP_HLT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      ret   <= RET_RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ret_nxt   = ret;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN: begin
        if (dmem_busy) begin
          state_nxt = ST_MEMWAIT;
          ret_nxt   = RET_RUN;
        end else if (hazard) begin
          // br_ex alone takes one extra bubble; a pending load into MEM is then caught by br_mem.
          state_nxt = ST_STALL;
          cnt_nxt   = (load_use | br_mem) ? 2'd1 : 2'd0;
        end else if (id_hlt) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end
      end
      ST_STALL: begin
        if (dmem_busy) begin
          state_nxt = ST_MEMWAIT;
          ret_nxt   = RET_STALL;
        end else if (cnt == 2'd0) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      ST_MEMWAIT: begin
        if (!dmem_busy) begin
          case (ret)
            RET_STALL: state_nxt = ST_STALL;
            RET_DRAIN: state_nxt = ST_DRAIN;
            default:   state_nxt = ST_RUN;
          endcase
        end
      end
      ST_DRAIN: begin
        if (dmem_busy) begin
          state_nxt = ST_MEMWAIT;
          ret_nxt   = RET_DRAIN;
        end else if (cnt == 2'd0) begin
          state_nxt = ST_HALT;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    halted       = 1'b0;
    case (state)
      ST_RUN: begin
        // Busy memory freezes everything, then hazards bubble ID; HLT suppresses the flush.
        if (!dmem_busy) begin
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          if (hazard) begin
            id_ex_bubble = 1'b1;
          end else begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = branch_taken && !id_hlt;
          end
        end
      end
      ST_STALL, ST_DRAIN: begin
        id_ex_bubble = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: each vector queues its expected
// output word, and a negedge monitor compares whatever the DUT presents.
module tb_hazard_ctrl;

  localparam logic [3:0] ADD = 4'h0;
  localparam logic [3:0] LW  = 4'h8;
  localparam logic [3:0] B   = 4'hC;
  localparam logic [3:0] BR  = 4'hD;
  localparam logic [3:0] HLT = 4'hF;

  // {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en, halted}
  localparam logic [6:0] NORM = 7'b1100110;
  localparam logic [6:0] STL  = 7'b0001110;
  localparam logic [6:0] FRZ  = 7'b0000000;
  localparam logic [6:0] FLU  = 7'b1110110;
  localparam logic [6:0] HLTD = 7'b0000001;

  typedef struct {
    logic [6:0] exp;
    string      name;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] IF_ID_Opcode, IF_ID_Rs, IF_ID_Rt;
  logic [3:0] ID_EX_Opcode, ID_EX_Rd, EX_MEM_Opcode, EX_MEM_Rd;
  logic       branch_taken, dmem_busy;
  logic       pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en, halted;

  item_t q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .OPW       (4),
    .RW        (4),
    .DRAIN_CYC (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .IF_ID_Opcode  (IF_ID_Opcode),
    .IF_ID_Rs      (IF_ID_Rs),
    .IF_ID_Rt      (IF_ID_Rt),
    .ID_EX_Opcode  (ID_EX_Opcode),
    .ID_EX_Rd      (ID_EX_Rd),
    .EX_MEM_Opcode (EX_MEM_Opcode),
    .EX_MEM_Rd     (EX_MEM_Rd),
    .branch_taken  (branch_taken),
    .dmem_busy     (dmem_busy),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .halted        (halted)
  );

  task automatic apply(input string nm, input logic r,
                       input logic [3:0] ifop, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] exop, input logic [3:0] exrd,
                       input logic [3:0] memop, input logic [3:0] memrd,
                       input logic bt, input logic busy, input logic [6:0] exp);
    item_t it;
    @(posedge clk);
    #1;
    rst           = r;
    IF_ID_Opcode  = ifop;
    IF_ID_Rs      = rs;
    IF_ID_Rt      = rt;
    ID_EX_Opcode  = exop;
    ID_EX_Rd      = exrd;
    EX_MEM_Opcode = memop;
    EX_MEM_Rd     = memrd;
    branch_taken  = bt;
    dmem_busy     = busy;
    it.exp  = exp;
    it.name = nm;
    q.push_back(it);
  endtask

  task automatic idle(input string nm, input logic r, input logic busy, input logic [6:0] exp);
    apply(nm, r, ADD, 4'd0, 4'd0, ADD, 4'd0, ADD, 4'd0, 1'b0, busy, exp);
  endtask

  // Monitor: one expected word is consumed per cycle the stimulus queued one.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        item_t      it;
        logic [6:0] act;
        it  = q.pop_front();
        act = {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en, halted};
        n_vec++;
        if (act !== it.exp) begin
          n_bad++;
          $display("FAIL %s: outputs %b, expected %b (pc,ifid,flush,bubble,exmem,memwb,halted)",
                   it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    IF_ID_Opcode = ADD; IF_ID_Rs = 4'd0; IF_ID_Rt = 4'd0;
    ID_EX_Opcode = ADD; ID_EX_Rd = 4'd0; EX_MEM_Opcode = ADD; EX_MEM_Rd = 4'd0;
    branch_taken = 1'b0; dmem_busy = 1'b0;

    idle("reset", 1'b1, 1'b0, NORM);
    idle("idle",  1'b0, 1'b0, NORM);

    // Load-use on Rs: detect cycle plus STALL with cnt=1 then cnt=0; taken branch ignored while held.
    apply("lu_rs",    1'b0, ADD, 4'd3, 4'd5, LW,  4'd3, ADD, 4'd0, 1'b0, 1'b0, STL);
    apply("lu_hold1", 1'b0, ADD, 4'd3, 4'd5, ADD, 4'd0, LW,  4'd3, 1'b1, 1'b0, STL);
    apply("lu_hold0", 1'b0, ADD, 4'd3, 4'd5, ADD, 4'd0, ADD, 4'd0, 1'b0, 1'b0, STL);
    apply("lu_clear", 1'b0, ADD, 4'd3, 4'd5, ADD, 4'd0, ADD, 4'd0, 1'b0, 1'b0, NORM);

    // Load-use through Rt, and an ID LW whose Rt field matches but is not read.
    apply("lu_rt",    1'b0, ADD, 4'd1, 4'd3, LW,  4'd3, ADD, 4'd0, 1'b0, 1'b0, STL);
    idle("lu_rt_h1", 1'b0, 1'b0, STL);
    idle("lu_rt_h0", 1'b0, 1'b0, STL);
    apply("lw_no_rt", 1'b0, LW,  4'd4, 4'd3, LW,  4'd3, ADD, 4'd0, 1'b0, 1'b0, NORM);

    // R0 sources never stall.
    apply("r0_lw",    1'b0, ADD, 4'd0, 4'd0, LW,  4'd0, ADD, 4'd0, 1'b0, 1'b0, NORM);
    apply("r0_br",    1'b0, BR,  4'd0, 4'd0, ADD, 4'd0, LW,  4'd0, 1'b0, 1'b0, NORM);

    // BR after ALU writer: detect plus one STALL cycle, then the resolved branch flushes.
    apply("brex",     1'b0, BR, 4'd2, 4'd0, ADD, 4'd2, ADD, 4'd0, 1'b0, 1'b0, STL);
    apply("brex_h",   1'b0, BR, 4'd2, 4'd0, ADD, 4'd0, ADD, 4'd2, 1'b0, 1'b0, STL);
    apply("brex_go",  1'b0, BR, 4'd2, 4'd0, ADD, 4'd0, ADD, 4'd0, 1'b1, 1'b0, FLU);
    idle("brex_next", 1'b0, 1'b0, NORM);

    // BR after LW in EX (load_use and br_ex together).
    apply("brlw",     1'b0, BR, 4'd2, 4'd0, LW,  4'd2, ADD, 4'd0, 1'b0, 1'b0, STL);
    apply("brlw_h1",  1'b0, BR, 4'd2, 4'd0, ADD, 4'd0, LW,  4'd2, 1'b0, 1'b0, STL);
    apply("brlw_h0",  1'b0, BR, 4'd2, 4'd0, ADD, 4'd0, ADD, 4'd0, 1'b0, 1'b0, STL);
    apply("brlw_go",  1'b0, BR, 4'd2, 4'd0, ADD, 4'd0, ADD, 4'd0, 1'b0, 1'b0, NORM);

    // BR with the producing LW already in MEM.
    apply("brmem",    1'b0, BR, 4'd5, 4'd0, ADD, 4'd0, LW,  4'd5, 1'b0, 1'b0, STL);
    apply("brmem_h1", 1'b0, BR, 4'd5, 4'd0, ADD, 4'd0, ADD, 4'd0, 1'b0, 1'b0, STL);
    apply("brmem_h0", 1'b0, BR, 4'd5, 4'd0, ADD, 4'd0, ADD, 4'd0, 1'b0, 1'b0, STL);
    apply("brmem_go", 1'b0, BR, 4'd5, 4'd0, ADD, 4'd0, ADD, 4'd0, 1'b0, 1'b0, NORM);

    // Taken branch with no hazard: one-cycle flush.
    apply("br_taken", 1'b0, B, 4'd0, 4'd0, ADD, 4'd0, ADD, 4'd0, 1'b1, 1'b0, FLU);
    idle("br_next",  1'b0, 1'b0, NORM);

    // Memory busy for 4 cycles while in STALL cnt=1; stall beats flush on entry.
    apply("mw_lu",    1'b0, ADD, 4'd3, 4'd0, LW, 4'd3, ADD, 4'd0, 1'b1, 1'b0, STL);
    idle("mw_b1",  1'b0, 1'b1, STL);
    idle("mw_b2",  1'b0, 1'b1, FRZ);
    idle("mw_b3",  1'b0, 1'b1, FRZ);
    idle("mw_b4",  1'b0, 1'b1, FRZ);
    idle("mw_rel", 1'b0, 1'b0, FRZ);
    idle("mw_s1",  1'b0, 1'b0, STL);
    idle("mw_s0",  1'b0, 1'b0, STL);
    idle("mw_run", 1'b0, 1'b0, NORM);

    // Memory busy in RUN freezes immediately.
    idle("rb_busy", 1'b0, 1'b1, FRZ);
    idle("rb_rel",  1'b0, 1'b0, FRZ);
    idle("rb_run",  1'b0, 1'b0, NORM);

    // HLT (wins over a taken branch): 3 drain cycles, sticky halt, reset clears.
    apply("hlt", 1'b0, HLT, 4'd0, 4'd0, ADD, 4'd0, ADD, 4'd0, 1'b1, 1'b0, NORM);
    idle("drain1",    1'b0, 1'b0, STL);
    idle("drain2",    1'b0, 1'b0, STL);
    idle("drain3",    1'b0, 1'b0, STL);
    idle("halted",    1'b0, 1'b0, HLTD);
    idle("halt_busy", 1'b0, 1'b1, HLTD);
    idle("halt_keep", 1'b0, 1'b0, HLTD);
    idle("halt_rst",  1'b1, 1'b0, NORM);
    idle("post_rst",  1'b0, 1'b0, NORM);

    // Reset asserted in the middle of DRAIN.
    apply("hlt2", 1'b0, HLT, 4'd0, 4'd0, ADD, 4'd0, ADD, 4'd0, 1'b0, 1'b0, NORM);
    idle("drain_a",   1'b0, 1'b0, STL);
    idle("drain_rst", 1'b1, 1'b0, NORM);
    idle("after_rst", 1'b0, 1'b0, NORM);
    apply("run_again", 1'b0, ADD, 4'd3, 4'd0, LW, 4'd3, ADD, 4'd0, 1'b0, 1'b0, STL);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue: %0d expected words left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
